// File: rtl/unidad_de_busqueda_if.sv
// unidad_de_busqueda_if: instruction-memory read handshake between the fetch stage (master) and memory (slave)
interface unidad_de_busqueda_if #(
  parameter int ANCHO_DIR   = 8,
  parameter int ANCHO_INSTR = 16
);
  logic                   Mem_Solicitud;
  logic [ANCHO_DIR-1:0]   Mem_Direccion;
  logic                   Mem_Listo;
  logic [ANCHO_INSTR-1:0] Mem_Dato;
  modport master (output Mem_Solicitud, Mem_Direccion, input Mem_Listo, Mem_Dato);
  modport slave  (input Mem_Solicitud, Mem_Direccion, output Mem_Listo, Mem_Dato);
endinterface

// File: rtl/unidad_de_busqueda.sv
// unidad_de_busqueda: prefetching instruction fetch stage feeding the control unit; BUSQUEDA_BYPASS_EN lets a response on an empty queue load Instruccion directly
module unidad_de_busqueda #(
  parameter int                   ANCHO_DIR       = 8,
  parameter int                   ANCHO_INSTR     = 16,
  parameter int                   PROF            = 4,
  parameter logic [ANCHO_DIR-1:0] VECTOR_REINICIO = '0
)(
  input  logic                    Reloj,
  input  logic                    Reiniciar,
  unidad_de_busqueda_if.master    mem,
  input  logic                    LoadIR,
  input  logic                    LoadPC,
  input  logic [1:0]              SelectPC,
  input  logic [ANCHO_DIR-1:0]    Destino,
  input  logic [ANCHO_DIR-1:0]    RegA,
  output logic [ANCHO_INSTR-1:0]  Instruccion,
  output logic                    Instruccion_Valida,
  output logic [ANCHO_DIR-1:0]    PC_Instr
);
  localparam int AP = $clog2(PROF);
  localparam logic [ANCHO_DIR-1:0] UNO = 1;
  typedef enum logic [1:0] {OCIOSO, ESPERA, DESCARTE} estado_t;
  estado_t                r_estado;
  logic                   r_sol;
  logic [ANCHO_DIR-1:0]   r_dir;
  logic [ANCHO_DIR-1:0]   r_pend;
  logic [ANCHO_INSTR-1:0] r_q_dato [PROF];
  logic [ANCHO_DIR-1:0]   r_q_dir  [PROF];
  logic [AP:0]            r_wr;
  logic [AP:0]            r_rd;
  logic [ANCHO_INSTR-1:0] r_instr;
  logic                   r_valida;
  logic [ANCHO_DIR-1:0]   r_pc;
  logic                   w_vacia;
  logic                   w_llena;
  logic                   w_listo;
  logic                   w_bypass;
  logic                   w_push;
  logic                   w_pop;
  logic [ANCHO_DIR-1:0]   w_destino;
  assign w_vacia   = r_wr == r_rd;
  assign w_llena   = (r_wr[AP] != r_rd[AP]) && (r_wr[AP-1:0] == r_rd[AP-1:0]);
  assign w_destino = SelectPC == 2'b00 ? r_pc + UNO :
                     SelectPC == 2'b01 ? Destino :
                     SelectPC == 2'b10 ? RegA : VECTOR_REINICIO;
  assign w_listo   = r_estado == ESPERA && mem.Mem_Listo;
`ifdef BUSQUEDA_BYPASS_EN
  assign w_bypass  = w_listo && LoadIR && !LoadPC && w_vacia;
`else
  assign w_bypass  = 1'b0;
`endif
  assign w_push    = w_listo && !LoadPC && !w_bypass;
  assign w_pop     = LoadIR && !LoadPC && !w_vacia;
  assign mem.Mem_Solicitud  = r_sol;
  assign mem.Mem_Direccion  = r_dir;
  assign Instruccion        = r_instr;
  assign Instruccion_Valida = r_valida;
  assign PC_Instr           = r_pc;
  // request FSM: one outstanding read; a redirect during a read is parked in r_pend so the address stays stable
  always_ff @(posedge Reloj or negedge Reiniciar)
    if (!Reiniciar) begin
      r_estado <= OCIOSO;
      r_sol    <= 1'b0;
      r_dir    <= VECTOR_REINICIO;
      r_pend   <= VECTOR_REINICIO;
    end else
      case (r_estado)
        OCIOSO: begin
          if (LoadPC) r_dir <= w_destino;
          if (LoadPC || !w_llena) begin
            r_estado <= ESPERA;
            r_sol    <= 1'b1;
          end
        end
        ESPERA:
          if (mem.Mem_Listo) begin
            r_estado <= OCIOSO;
            r_sol    <= 1'b0;
            r_dir    <= LoadPC ? w_destino : r_dir + UNO;
          end else if (LoadPC) begin
            r_estado <= DESCARTE;
            r_pend   <= w_destino;
          end
        DESCARTE: begin
          if (LoadPC) r_pend <= w_destino;
          if (mem.Mem_Listo) begin
            r_estado <= OCIOSO;
            r_sol    <= 1'b0;
            r_dir    <= LoadPC ? w_destino : r_pend;
          end
        end
        default: begin
          r_estado <= OCIOSO;
          r_sol    <= 1'b0;
        end
      endcase
  // queue storage: address and word of each kept response
  always_ff @(posedge Reloj)
    if (w_push) begin
      r_q_dato[r_wr[AP-1:0]] <= mem.Mem_Dato;
      r_q_dir[r_wr[AP-1:0]]  <= r_dir;
    end
  // queue pointers: a redirect empties the queue
  always_ff @(posedge Reloj or negedge Reiniciar)
    if (!Reiniciar) begin
      r_wr <= '0;
      r_rd <= '0;
    end else if (LoadPC) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      r_wr <= r_wr + {{AP{1'b0}}, w_push};
      r_rd <= r_rd + {{AP{1'b0}}, w_pop};
    end
  // instruction register: head of queue (or bypassed word) on LoadIR, invalidated by redirect or empty pop
  always_ff @(posedge Reloj or negedge Reiniciar)
    if (!Reiniciar) begin
      r_instr  <= '0;
      r_valida <= 1'b0;
      r_pc     <= '0;
    end else if (LoadPC)
      r_valida <= 1'b0;
    else if (LoadIR) begin
      r_valida <= w_pop || w_bypass;
      if (w_pop) begin
        r_instr <= r_q_dato[r_rd[AP-1:0]];
        r_pc    <= r_q_dir[r_rd[AP-1:0]];
      end else if (w_bypass) begin
        r_instr <= mem.Mem_Dato;
        r_pc    <= r_dir;
      end
    end
endmodule
